bp_sacc_he_dma_sequencer: RTL
=============================

Name: bp_sacc_he_dma_sequencer

Overview:
- Sequences DMA fills of the HE accelerator's sample scratchpads (u, e1, m_e0) from memory. It replaces the ad-hoc FETCH/WAIT_DMA loop in the accelerator top.
- Loaded by CSR logic with base address, word count and target SPM. It then issues 4-byte uncached reads with bounded outstanding credits and writes returned words, in order, into the selected SPM.
- Reports busy/done/error back to the CSR block.

Parameters:
- paddr_width_p, 40, physical address width.
- data_width_p, 32, word width returned per read and written per SPM write.
- spm_els_p, 4096, words per scratchpad; also the maximum transfer length.
- spm_sel_width_p, 2, SPM select width (0=u, 1=e1, 2=m_e0, 3=reserved).
- max_outstanding_p, 4, maximum reads in flight (1..8).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start pulse from CSR block.
- base_addr_i  in  paddr_width_p  byte address of the first word.
- length_i  in  $clog2(spm_els_p)+1  word count.
- spm_sel_i  in  spm_sel_width_p  target SPM.
- clear_i  in  1  clears done_o/err_o.
- busy_o  out  1  transfer in progress.
- done_o  out  1  sticky completion flag.
- err_o  out  1  sticky error flag.
- words_done_o  out  $clog2(spm_els_p)+1  words written so far.
- mem_cmd_v_o  out  1  read request valid.
- mem_cmd_addr_o  out  paddr_width_p  read address.
- mem_cmd_yumi_i  in  1  request consumed.
- mem_resp_v_i  in  1  read data valid.
- mem_resp_data_i  in  data_width_p  read data.
- mem_resp_ready_o  out  1  always 1 (responses never stalled).
- spm_w_v_o  out  1  SPM write strobe.
- spm_sel_o  out  spm_sel_width_p  SPM targeted by the write.
- spm_addr_o  out  $clog2(spm_els_p)  SPM word index.
- spm_data_o  out  data_width_p  write data.

Behaviour:
- Reset (reset_n_i low, asynchronous): state IDLE; all outputs 0 except mem_resp_ready_o=1; all counters 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start_i, latch base_addr_i with bits [1:0] forced to 0, latch spm_sel_i, and latch length clamped to spm_els_p.
  - Clear done_o, issue counter, write counter and outstanding count.
  - Next state ISSUE if length != 0; otherwise DONE.
  - err_o is set if spm_sel_i==3 or length_i>spm_els_p. The transfer still proceeds, with sel forced to 0 when sel==3.
- ISSUE:
  - mem_cmd_v_o = (issued < length) && (outstanding < max_outstanding_p).
  - mem_cmd_addr_o = base + 4*issued.
  - cmd_v/addr are combinational from registers and stay stable until yumi.
  - On yumi: issued++, outstanding++.
  - Go to DRAIN in the cycle after issued reaches length.
- Response handling (ISSUE and DRAIN):
  - Each mem_resp_v_i: outstanding--, capture data.
  - Next cycle: spm_w_v_o=1, spm_addr_o=written, spm_sel_o=latched sel, spm_data_o=data; written++.
  - Same-cycle yumi and response: outstanding unchanged.
- DRAIN → DONE when written==length and outstanding==0. done_o=1 and busy_o=0 on entry.
- busy_o=1 in ISSUE and DRAIN.
- DONE: done_o held until clear_i or the next start_i; returns to IDLE in the next cycle.
- start_i while busy: ignored; err_o set.
- mem_resp_v_i with outstanding==0: data dropped, no SPM write, err_o set.
- clear_i and start_i in the same cycle: start wins for done_o (cleared); err_o cleared, then re-evaluated for the new start.
- Address arithmetic is modulo 2^paddr_width_p; wrap is silent.
- Latency: start → first mem_cmd_v_o 1 cycle. Last response at cycle t → last SPM write at t+1 → done_o at t+2.

Optional Feature:
- Macro: BP_SACC_HE_DMA_PERF_EN.
- Defined: adds output cycles_o (32 bits). It counts cycles spent in ISSUE+DRAIN, resets on start_i and saturates at all-ones.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Basic fill: start, base=0x0010_0000, len=8, sel=1, yumi every cycle, response 2 cycles after yumi with data=addr[31:0]. Required: 8 reads at 0x100000..0x10001C; SPM e1 words 0..7 = those addresses; done_o=1 two cycles after last response; err_o=0.
- Credit limit: max_outstanding_p=4, len=16, responses withheld. Required: exactly 4 yumis and mem_cmd_v_o then low; releasing one response allows exactly one more request.
- Zero length: len=0. Required: no mem_cmd_v_o; done_o=1 one cycle after start.
- Clamp/err: len=5000, sel=3, base=0x3. Required: 4096 reads starting 0x0; sel_o=0; err_o=1; done_o=1.
- Spurious response / start while busy: mem_resp_v_i in IDLE, then start during ISSUE. Required: no spm_w_v_o; err_o=1; original transfer completes unaltered.
- Async reset mid-transfer: reset_n_i low during DRAIN at len=8 after 3 writes. Required: outputs 0 immediately without a clock edge; after release, a new len=2 transfer completes normally.

Source files
------------

// File: rtl/bp_sacc_he_dma_sequencer.sv
// Purpose : sequences DMA fills of the HE sample scratchpads (u, e1, m_e0) from
//           memory using 4-byte uncached reads with bounded outstanding credits.
// Latency : start -> first read request 1 cycle; last response at t -> last SPM
//           write at t+1 -> done_o at t+2.
// Backpressure: requests held stable until mem_cmd_yumi_i; responses are never
//           stalled (mem_resp_ready_o tied high).
//
// Ports:
//   clk_i, reset_n_i (async, active-low)
//   CSR side  : start_i, base_addr_i, length_i, spm_sel_i, clear_i,
//               busy_o, done_o, err_o, words_done_o
//   Memory    : mem_cmd_v_o/mem_cmd_addr_o/mem_cmd_yumi_i,
//               mem_resp_v_i/mem_resp_data_i/mem_resp_ready_o
//   SPM write : spm_w_v_o, spm_sel_o, spm_addr_o, spm_data_o
//   Optional  : cycles_o (32b), present only when BP_SACC_HE_DMA_PERF_EN is
//               defined; counts ISSUE+DRAIN cycles, resets on start, saturates.

module bp_sacc_he_dma_sequencer #(
  parameter int paddr_width_p     = 40,
  parameter int data_width_p      = 32,
  parameter int spm_els_p         = 4096,
  parameter int spm_sel_width_p   = 2,
  parameter int max_outstanding_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,

  input  logic                           start_i,
  input  logic [paddr_width_p-1:0]       base_addr_i,
  input  logic [$clog2(spm_els_p):0]     length_i,
  input  logic [spm_sel_width_p-1:0]     spm_sel_i,
  input  logic                           clear_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [$clog2(spm_els_p):0]     words_done_o,

  output logic                           mem_cmd_v_o,
  output logic [paddr_width_p-1:0]       mem_cmd_addr_o,
  input  logic                           mem_cmd_yumi_i,
  input  logic                           mem_resp_v_i,
  input  logic [data_width_p-1:0]        mem_resp_data_i,
  output logic                           mem_resp_ready_o,

  output logic                           spm_w_v_o,
  output logic [spm_sel_width_p-1:0]     spm_sel_o,
  output logic [$clog2(spm_els_p)-1:0]   spm_addr_o,
  output logic [data_width_p-1:0]        spm_data_o
`ifdef BP_SACC_HE_DMA_PERF_EN
  ,
  output logic [31:0]                    cycles_o
`endif
);

  localparam int lg_els_lp = $clog2(spm_els_p);
  localparam int len_w_lp  = lg_els_lp + 1;
  localparam int out_w_lp  = $clog2(max_outstanding_p + 1);

  localparam logic [len_w_lp-1:0]        max_len_lp   = len_w_lp'(spm_els_p);
  localparam logic [out_w_lp-1:0]        max_out_lp   = out_w_lp'(max_outstanding_p);
  localparam logic [spm_sel_width_p-1:0] sel_rsvd_lp  = spm_sel_width_p'(3);
  localparam logic [paddr_width_p-1:0]   word_mask_lp = ~paddr_width_p'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                     state_q,   state_d;
  logic [paddr_width_p-1:0]   base_q,    base_d;
  logic [len_w_lp-1:0]        len_q,     len_d;
  logic [spm_sel_width_p-1:0] sel_q,     sel_d;
  logic [len_w_lp-1:0]        issued_q,  issued_d;
  logic [len_w_lp-1:0]        written_q, written_d;
  logic [out_w_lp-1:0]        outst_q,   outst_d;
  logic                       busy_q,    busy_d;
  logic                       done_q,    done_d;
  logic                       err_q,     err_d;
  logic                       wr_v_q,    wr_v_d;
  logic [data_width_p-1:0]    wr_data_q, wr_data_d;
`ifdef BP_SACC_HE_DMA_PERF_EN
  logic [31:0]                cycles_q,  cycles_d;
`endif

  logic                fire, resp_ok, resp_bad, start_ok, bad_cfg;
  logic [len_w_lp-1:0] len_clamp, written_n;
  logic [out_w_lp-1:0] outst_n;

  // Request valid/address are pure functions of registered state, so they
  // stay stable while the memory side withholds yumi.
  assign mem_cmd_v_o    = (state_q == ISSUE) && (issued_q < len_q) && (outst_q < max_out_lp);
  assign mem_cmd_addr_o = base_q + paddr_width_p'({issued_q, 2'b00});

  assign fire      = mem_cmd_v_o & mem_cmd_yumi_i;
  // A response with nothing in flight is dropped and flagged.
  assign resp_ok   = mem_resp_v_i & (outst_q != '0);
  assign resp_bad  = mem_resp_v_i & (outst_q == '0);
  assign start_ok  = start_i & ((state_q == IDLE) | (state_q == DONE));
  assign bad_cfg   = (spm_sel_i == sel_rsvd_lp) | (length_i > max_len_lp);
  assign len_clamp = (length_i > max_len_lp) ? max_len_lp : length_i;

  // Counter values after this cycle's events; completion is judged on these
  // so done_o rises the cycle after the last SPM write.
  assign written_n = written_q + len_w_lp'(wr_v_q);
  assign outst_n   = outst_q + out_w_lp'(fire) - out_w_lp'(resp_ok);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    sel_d     = sel_q;
    issued_d  = issued_q + len_w_lp'(fire);
    written_d = written_n;
    outst_d   = outst_n;
    done_d    = done_q;
    err_d     = err_q;
    wr_v_d    = resp_ok;
    wr_data_d = resp_ok ? mem_resp_data_i : wr_data_q;
`ifdef BP_SACC_HE_DMA_PERF_EN
    cycles_d  = cycles_q;
    if (((state_q == ISSUE) || (state_q == DRAIN)) && (cycles_q != '1)) begin
      cycles_d = cycles_q + 32'd1;
    end
`endif

    if (clear_i) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (resp_bad) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start_ok) begin
          base_d    = base_addr_i & word_mask_lp;
          sel_d     = (spm_sel_i == sel_rsvd_lp) ? '0 : spm_sel_i;
          len_d     = len_clamp;
          issued_d  = '0;
          written_d = '0;
          outst_d   = '0;
          done_d    = 1'b0;
          err_d     = err_d | bad_cfg;
`ifdef BP_SACC_HE_DMA_PERF_EN
          cycles_d  = '0;
`endif
          if (len_clamp == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (start_i) begin
          err_d = 1'b1;
        end
        if (issued_q == len_q) begin
          if ((written_n == len_q) && (outst_n == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (start_i) begin
          err_d = 1'b1;
        end
        if ((written_n == len_q) && (outst_n == '0)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      sel_q     <= '0;
      issued_q  <= '0;
      written_q <= '0;
      outst_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_v_q    <= 1'b0;
      wr_data_q <= '0;
`ifdef BP_SACC_HE_DMA_PERF_EN
      cycles_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      sel_q     <= sel_d;
      issued_q  <= issued_d;
      written_q <= written_d;
      outst_q   <= outst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_v_q    <= wr_v_d;
      wr_data_q <= wr_data_d;
`ifdef BP_SACC_HE_DMA_PERF_EN
      cycles_q  <= cycles_d;
`endif
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign words_done_o     = written_q;
  assign mem_resp_ready_o = 1'b1;
  assign spm_w_v_o        = wr_v_q;
  assign spm_sel_o        = sel_q;
  assign spm_addr_o       = written_q[lg_els_lp-1:0];
  assign spm_data_o       = wr_data_q;
`ifdef BP_SACC_HE_DMA_PERF_EN
  assign cycles_o         = cycles_q;
`endif

endmodule
